tcu_uop_scheduler: RTL and testbench

- Shares one TCU uop expander among NUM_REQS instruction requesters (per-warp ibuffer heads) using round-robin arbitration.
- Non-TCU instructions pass through as single beats.
- For a TCU instruction, the grant is locked while the external expander is sequenced with its start/next/done handshake, so UOPS uops reach the downstream issue port back-to-back.
- Sits between the ibuffers and the scoreboard/issue stage.

---
 rtl/VX_tcu_pkg.sv | 11 +
 rtl/tcu_rr_pick.sv | 30 +++
 rtl/tcu_uop_scheduler.sv | 153 +++++++++++++++
 tb/tb_tcu_uop_scheduler.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/VX_tcu_pkg.sv
// Shared TCU definitions: uops per TCU instruction and the expander handshake bundle.
package VX_tcu_pkg;

   localparam int unsigned TCU_UOPS = 8;

   typedef struct packed {
      logic start;
      logic next;
   } tcu_uop_ctrl_t;

endpackage

// File: rtl/tcu_rr_pick.sv
// Combinational round-robin pick: first valid index at or after ptr, wrapping.
module tcu_rr_pick #(
   parameter int unsigned NUM_REQS = 4,
   parameter int unsigned IDX_W    = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1
) (
   input  logic [NUM_REQS-1:0] valid,
   input  logic [IDX_W-1:0]    ptr,
   output logic [NUM_REQS-1:0] grant_oh,
   output logic [IDX_W-1:0]    grant_idx,
   output logic                any_valid
);

   logic [IDX_W-1:0] j;

   always_comb begin
      grant_oh  = '0;
      grant_idx = '0;
      any_valid = 1'b0;
      j         = '0;
      for (int unsigned i = 0; i < NUM_REQS; i++) begin
         j = IDX_W'((32'(ptr) + i) % NUM_REQS);
         if (!any_valid && valid[j]) begin
            any_valid   = 1'b1;
            grant_idx   = j;
            grant_oh[j] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/tcu_uop_scheduler.sv
// Round-robin issue of ibuffer heads; TCU ops hold the grant while the shared expander
// streams UOPS uops to the downstream port.
module tcu_uop_scheduler
   import VX_tcu_pkg::*;
#(
   parameter int unsigned NUM_REQS = 4,
   parameter int unsigned DATA_W   = 64,
   parameter int unsigned UOPS     = TCU_UOPS,
   parameter int unsigned IDX_W    = (UOPS > 1) ? $clog2(UOPS) : 1,
   parameter int unsigned REQ_W    = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [NUM_REQS-1:0]        req_valid,
   input  logic [NUM_REQS-1:0]        req_is_tcu,
   input  logic [NUM_REQS*DATA_W-1:0] req_data,
   output logic [NUM_REQS-1:0]        req_ready,
   output logic                       exp_start,
   output logic                       exp_next,
   output logic [DATA_W-1:0]          exp_in_data,
   input  logic                       exp_done,
   input  logic [DATA_W-1:0]          exp_out_data,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [DATA_W-1:0]          out_data,
   output logic [REQ_W-1:0]           out_req_id,
   output logic [IDX_W-1:0]           out_uop_idx,
   output logic                       out_last,
   output logic                       err_overrun
);

   typedef enum logic [1:0] {StIdle, StPass, StStart, StIssue} state_e;

   state_e               state_q, state_d;
   logic [REQ_W-1:0]     rr_ptr_q, rr_ptr_d;
   logic [REQ_W-1:0]     grant_q, grant_d, grant_nxt;
   logic [IDX_W-1:0]     uop_cnt_q, uop_cnt_d;
   logic                 err_overrun_q, err_overrun_d;
   logic [NUM_REQS-1:0]  pick_oh;
   logic [REQ_W-1:0]     pick_idx;
   logic                 pick_any;
   logic [DATA_W-1:0]    grant_data;
   tcu_uop_ctrl_t        exp_ctrl;

   tcu_rr_pick #(
      .NUM_REQS (NUM_REQS),
      .IDX_W    (REQ_W)
   ) u_pick (
      .valid     (req_valid),
      .ptr       (rr_ptr_q),
      .grant_oh  (pick_oh),
      .grant_idx (pick_idx),
      .any_valid (pick_any)
   );

   assign grant_data  = req_data[32'(grant_q) * DATA_W +: DATA_W];
   assign grant_nxt   = (grant_q == REQ_W'(NUM_REQS - 1)) ? '0 : grant_q + 1'b1;
   assign exp_start   = exp_ctrl.start;
   assign exp_next    = exp_ctrl.next;
   assign err_overrun = err_overrun_q & ~reset;

   always_comb begin
      state_d       = state_q;
      rr_ptr_d      = rr_ptr_q;
      grant_d       = grant_q;
      uop_cnt_d     = uop_cnt_q;
      err_overrun_d = err_overrun_q;
      req_ready     = '0;
      exp_ctrl      = '0;
      exp_in_data   = '0;
      out_valid     = 1'b0;
      out_data      = '0;
      out_req_id    = '0;
      out_uop_idx   = '0;
      out_last      = 1'b0;
      case (state_q)
         StIdle: begin
            if (pick_any) begin
               grant_d = pick_idx;
               state_d = |(req_is_tcu & pick_oh) ? StStart : StPass;
            end
         end
         StPass: begin
            out_valid  = 1'b1;
            out_data   = grant_data;
            out_req_id = grant_q;
            out_last   = 1'b1;
            if (out_ready) begin
               req_ready[grant_q] = 1'b1;
               rr_ptr_d           = grant_nxt;
               state_d            = StIdle;
            end
         end
         StStart: begin
            exp_ctrl.start = 1'b1;
            exp_in_data    = grant_data;
            uop_cnt_d      = '0;
            state_d        = StIssue;
         end
         StIssue: begin
            exp_in_data   = grant_data;
            out_valid     = 1'b1;
            out_data      = exp_out_data;
            out_req_id    = grant_q;
            out_uop_idx   = uop_cnt_q;
            out_last      = exp_done;
            exp_ctrl.next = out_ready;
            if (out_ready) begin
               // A missing done on the last legal uop releases anyway so issue never wedges.
               if (exp_done || uop_cnt_q == IDX_W'(UOPS - 1)) begin
                  req_ready[grant_q] = 1'b1;
                  rr_ptr_d           = grant_nxt;
                  state_d            = StIdle;
                  if (!exp_done) err_overrun_d = 1'b1;
               end else begin
                  uop_cnt_d = uop_cnt_q + 1'b1;
               end
            end
         end
         default: state_d = StIdle;
      endcase
      if (reset) begin
         req_ready   = '0;
         exp_ctrl    = '0;
         exp_in_data = '0;
         out_valid   = 1'b0;
         out_data    = '0;
         out_req_id  = '0;
         out_uop_idx = '0;
         out_last    = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= StIdle;
         rr_ptr_q      <= '0;
         grant_q       <= '0;
         uop_cnt_q     <= '0;
         err_overrun_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         rr_ptr_q      <= rr_ptr_d;
         grant_q       <= grant_d;
         uop_cnt_q     <= uop_cnt_d;
         err_overrun_q <= err_overrun_d;
      end
   end

   // The owning requester must hold its head until popped.
   assert property (@(posedge clk) disable iff (reset) (state_q != StIdle) |-> req_valid[grant_q]);

endmodule

// File: tb/tb_tcu_uop_scheduler.sv
// Randomized and directed bench for tcu_uop_scheduler against a transaction-level model.
module tb_tcu_uop_scheduler;

   localparam int unsigned N  = 4;
   localparam int unsigned DW = 64;
   localparam int unsigned U  = 8;
   localparam logic [DW-1:0] Step = 64'h0000_0101_0101_0101;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   logic [N-1:0]    r_valid, r_tcu;
   logic [DW-1:0]   r_data [N];
   logic [N*DW-1:0] req_data;
   logic [N-1:0]    req_ready;
   logic            exp_start, exp_next, exp_done;
   logic [DW-1:0]   exp_in_data, exp_out_data;
   logic            out_valid, out_ready, out_last, err_overrun;
   logic [DW-1:0]   out_data;
   logic [1:0]      out_req_id;
   logic [2:0]      out_uop_idx;

   always_comb begin
      req_data = '0;
      for (int i = 0; i < N; i++) req_data[i*DW +: DW] = r_data[i];
   end

   tcu_uop_scheduler #(.NUM_REQS(N), .DATA_W(DW), .UOPS(U)) dut (
      .clk(clk), .reset(reset), .req_valid(r_valid), .req_is_tcu(r_tcu), .req_data(req_data),
      .req_ready(req_ready), .exp_start(exp_start), .exp_next(exp_next),
      .exp_in_data(exp_in_data), .exp_done(exp_done), .exp_out_data(exp_out_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_req_id(out_req_id), .out_uop_idx(out_uop_idx), .out_last(out_last),
      .err_overrun(err_overrun)
   );

   // Stub expander: uop k of instruction d is d + k*Step; done on uop U-1 unless disabled.
   logic [DW-1:0] stub_base;
   int unsigned   stub_k;
   bit            never_done;
   always_ff @(posedge clk) begin
      if (reset) begin
         stub_base <= '0;
         stub_k    <= 0;
      end else if (exp_start) begin
         stub_base <= exp_in_data;
         stub_k    <= 0;
      end else if (exp_next) begin
         stub_k <= stub_k + 1;
      end
   end
   assign exp_out_data = stub_base + DW'(stub_k) * Step;
   assign exp_done     = !never_done && (stub_k == U - 1);

   // Second build with a single uop per TCU op.
   logic [1:0]  r2_valid, r2_tcu, req2_ready;
   logic [31:0] r2_data;
   logic        exp2_start, exp2_next, out2_valid, out2_ready, out2_last, err2_overrun;
   logic [15:0] exp2_in_data, out2_data;
   logic [0:0]  out2_req_id, out2_uop_idx;

   tcu_uop_scheduler #(.NUM_REQS(2), .DATA_W(16), .UOPS(1)) dut2 (
      .clk(clk), .reset(reset), .req_valid(r2_valid), .req_is_tcu(r2_tcu), .req_data(r2_data),
      .req_ready(req2_ready), .exp_start(exp2_start), .exp_next(exp2_next),
      .exp_in_data(exp2_in_data), .exp_done(1'b1), .exp_out_data(~exp2_in_data),
      .out_valid(out2_valid), .out_ready(out2_ready), .out_data(out2_data),
      .out_req_id(out2_req_id), .out_uop_idx(out2_uop_idx), .out_last(out2_last),
      .err_overrun(err2_overrun)
   );

   typedef struct {
      logic [DW-1:0] data;
      int unsigned   rid;
      int unsigned   idx;
      bit            last;
   } beat_t;

   beat_t       exp_q[$];
   int          m_phase;
   int unsigned m_ptr, m_cur;
   bit          m_tcu, m_ovr, m_err;
   logic [N-1:0] pop_mask;
   int          checks   = 0;
   int          failures = 0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
      end
   endtask

   function automatic int unsigned rr_winner();
      for (int unsigned k = 0; k < N; k++)
         if (r_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
      return 0;
   endfunction

   task automatic raise(input int unsigned i, input bit tcu, input logic [DW-1:0] d);
      r_valid[i] = 1'b1;
      r_tcu[i]   = tcu;
      r_data[i]  = d;
   endtask

   // One clock: called just after a falling edge with requests already driven.
   task automatic tick(input bit rdy);
      logic [N-1:0] want_rr;
      beat_t        b;
      out_ready = rdy;
      #1;
      want_rr = '0;
      check_eq("err_overrun", err_overrun, reset ? 1'b0 : m_err);
      if (reset) begin
         check_eq("rst_out_valid", out_valid, 0);
         check_eq("rst_req_ready", req_ready, 0);
         check_eq("rst_exp_start", exp_start, 0);
         check_eq("rst_exp_next", exp_next, 0);
         check_eq("rst_out_data", out_data, 0);
         check_eq("rst_out_last", out_last, 0);
         check_eq("rst_uop_idx", out_uop_idx, 0);
         exp_q.delete();
         m_phase = 0;
         m_ptr   = 0;
         m_err   = 1'b0;
      end else if (m_phase == 0) begin
         check_eq("idle_out_valid", out_valid, 0);
         check_eq("idle_req_ready", req_ready, 0);
         check_eq("idle_exp_start", exp_start, 0);
         check_eq("idle_exp_next", exp_next, 0);
         if (r_valid != '0) begin
            m_cur = rr_winner();
            m_tcu = r_tcu[m_cur];
            m_ovr = m_tcu && never_done;
            if (m_tcu) begin
               for (int unsigned k = 0; k < U; k++)
                  exp_q.push_back('{r_data[m_cur] + DW'(k) * Step, m_cur, k, !m_ovr && k == U - 1});
               m_phase = 1;
            end else begin
               exp_q.push_back('{r_data[m_cur], m_cur, 0, 1'b1});
               m_phase = 2;
            end
         end
      end else if (m_phase == 1) begin
         check_eq("start_pulse", exp_start, 1);
         check_eq("start_out_valid", out_valid, 0);
         check_eq("start_in_data", exp_in_data, r_data[m_cur]);
         check_eq("start_req_ready", req_ready, 0);
         m_phase = 2;
      end else begin
         b = exp_q[0];
         check_eq("out_valid", out_valid, 1);
         check_eq("out_data", out_data, b.data);
         check_eq("out_req_id", out_req_id, b.rid);
         check_eq("out_uop_idx", out_uop_idx, b.idx);
         check_eq("out_last", out_last, b.last);
         check_eq("exp_start_busy", exp_start, 0);
         check_eq("exp_next", exp_next, m_tcu ? rdy : 1'b0);
         if (m_tcu) check_eq("exp_in_data", exp_in_data, r_data[m_cur]);
         if (rdy && exp_q.size() == 1) want_rr[m_cur] = 1'b1;
         check_eq("req_ready", req_ready, want_rr);
         if (rdy) begin
            exp_q.delete(0);
            if (exp_q.size() == 0) begin
               m_phase         = 0;
               m_ptr           = (m_cur + 1) % N;
               pop_mask[m_cur] = 1'b1;
               if (m_ovr) m_err = 1'b1;
            end
         end
      end
      @(negedge clk);
      r_valid  = r_valid & ~pop_mask;
      pop_mask = '0;
   endtask

   task automatic drain();
      for (int c = 0; c < 200 && (r_valid != '0 || m_phase != 0); c++) tick(1'b1);
      check_eq("drain_done", {63'd0, (r_valid != '0 || m_phase != 0)}, 0);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick(1'b0);
      tick(1'b0);
      reset = 1'b0;
   endtask

   initial begin
      reset      = 1'b1;
      out_ready  = 1'b0;
      r_valid    = '0;
      r_tcu      = '0;
      for (int i = 0; i < N; i++) r_data[i] = '0;
      never_done = 1'b0;
      pop_mask   = '0;
      m_phase    = 0;
      m_ptr      = 0;
      m_err      = 1'b0;
      r2_valid   = '0;
      r2_tcu     = '0;
      r2_data    = '0;
      out2_ready = 1'b0;
      @(negedge clk);
      do_reset();

      // Single pass-through op from requester 0.
      raise(0, 1'b0, 64'hA5);
      repeat (4) tick(1'b1);

      // TCU op from requester 2 at full throughput.
      raise(2, 1'b1, 64'h1111_2222_3333_4440);
      repeat (12) tick(1'b1);

      // All four pass-through requesters kept busy from a fresh pointer.
      do_reset();
      for (int c = 0; c < 20; c++) begin
         for (int i = 0; i < N; i++) if (!r_valid[i]) raise(i, 1'b0, {$urandom(), $urandom()});
         tick(1'b1);
      end
      drain();

      // Downstream back-pressure during a TCU op.
      raise(1, 1'b1, 64'h0BAD_F00D_0000_1000);
      for (int c = 0; c < 40; c++) tick(c % 3 == 0);
      drain();

      // Expander that never signals done, followed by a queued pass-through.
      never_done = 1'b1;
      raise(3, 1'b1, 64'h7777_0000_0000_0000);
      raise(0, 1'b0, 64'h0000_0000_0000_00C3);
      drain();
      repeat (3) tick(1'b1);
      never_done = 1'b0;

      // Reset while uop 3 is presented; the same request restarts from uop 0.
      raise(2, 1'b1, 64'h2222_0000_0000_0200);
      repeat (5) tick(1'b1);
      reset = 1'b1;
      tick(1'b1);
      reset = 1'b0;
      drain();

      // Random traffic.
      for (int c = 0; c < 600; c++) begin
         for (int i = 0; i < N; i++)
            if (!r_valid[i] && $urandom_range(3) == 0)
               raise(i, $urandom_range(2) == 0, {$urandom(), $urandom()});
         tick($urandom_range(3) != 0);
      end
      drain();

      // Single-uop build: TCU op from requester 1.
      r2_valid   = 2'b10;
      r2_tcu     = 2'b10;
      r2_data    = {16'h1234, 16'h0000};
      out2_ready = 1'b1;
      #1;
      check_eq("u1_idle_valid", out2_valid, 0);
      @(negedge clk); #1;
      check_eq("u1_start", exp2_start, 1);
      check_eq("u1_start_valid", out2_valid, 0);
      @(negedge clk); #1;
      check_eq("u1_valid", out2_valid, 1);
      check_eq("u1_data", out2_data, 16'hEDCB);
      check_eq("u1_last", out2_last, 1);
      check_eq("u1_idx", out2_uop_idx, 0);
      check_eq("u1_req_id", out2_req_id, 1);
      check_eq("u1_req_ready", req2_ready, 2'b10);
      check_eq("u1_err", err2_overrun, 0);
      @(negedge clk);
      r2_valid = '0;
      #1;
      check_eq("u1_after_valid", out2_valid, 0);
      check_eq("u1_after_ready", req2_ready, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
